// File: rtl/regfile_wb_sched_pkg.sv
// Shared definitions for the register-file write-back scheduler.
//   AW_DEFAULT / DW_DEFAULT : default register-address and data widths
//   NUM_REGS                : architectural register count (width of the pend bitmap)
//   lu_state_e              : long-unit arbitration FSM encoding
//   REG_ZERO                : hard-wired zero register, never tracked as pending
package regfile_wb_sched_pkg;

    localparam int unsigned AW_DEFAULT = 5;
    localparam int unsigned DW_DEFAULT = 32;
    localparam int unsigned NUM_REGS   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } lu_state_e;

    localparam logic [AW_DEFAULT-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regwb_scoreboard.sv
// Pending-write scoreboard for the 32-entry register file.
// Holds one bit per register that is set when an instruction writing that register issues and
// cleared when its result reaches the write port. Produces the issue stall for RAW/WAW hazards.
//   clk, rst          : clock, synchronous active-high reset
//   set_en_i/addr_i   : accepted issue with a destination register
//   clr_en_i/addr_i   : register file write this cycle
//   issue_*_i         : operands of the instruction presented by decode
//   force_bubble_i    : extra stall request from the write-port arbiter
//   issue_stall_o     : hold decode this cycle
//   pend_o            : registered scoreboard bitmap
module regwb_scoreboard
    import regfile_wb_sched_pkg::*;
#(
    parameter int unsigned AW = AW_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                set_en_i,
    input  logic [AW-1:0]       set_addr_i,
    input  logic                clr_en_i,
    input  logic [AW-1:0]       clr_addr_i,
    input  logic                issue_valid_i,
    input  logic                issue_wen_i,
    input  logic [AW-1:0]       issue_rs_i,
    input  logic [AW-1:0]       issue_rt_i,
    input  logic [AW-1:0]       issue_rd_i,
    input  logic                force_bubble_i,
    output logic                issue_stall_o,
    output logic [NUM_REGS-1:0] pend_o
);

    logic [NUM_REGS-1:0] pend_q, pend_d;

    // Clear first, then set, so a colliding set wins. r0 is never marked.
    always_comb begin
        pend_d = pend_q;
        if (clr_en_i) begin
            pend_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i && (set_addr_i != AW'(REG_ZERO))) begin
            pend_d[set_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Uses the registered bitmap only; a write-back in this cycle does not unblock until next.
    // pend_q[0] is always 0, so r0 operands never stall.
    always_comb begin
        issue_stall_o = issue_valid_i &&
                        (pend_q[issue_rs_i] || pend_q[issue_rt_i] ||
                         (issue_wen_i && pend_q[issue_rd_i]) || force_bubble_i);
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the register file's single write port.
// The ALU write-back always wins the port; the long unit (mult/div) is served in ALU-idle
// cycles. A scoreboard tracks in-flight destinations and stalls issue on RAW/WAW hazards.
// Optional feature macro REGWB_STARVE_EN: when defined, a starvation counter forces issue
// bubbles once the long unit has been blocked long enough, so the ALU stream drains and the
// long unit gets the port. When undefined, the FSM only has IDLE/WAIT and never stalls issue.
//   clk, rst                 : clock, synchronous active-high reset
//   issue_*                  : decode/issue interface, issue_stall_o holds decode
//   alu_wb_*                 : ALU write-back, no backpressure
//   lu_wb_* / lu_wb_ready_o  : long-unit write-back, held until ready
//   rf_we_o/waddr_o/wdat_o   : register file write port (combinational)
//   pend_o                   : scoreboard bitmap
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int unsigned AW         = AW_DEFAULT,
    parameter int unsigned DW         = DW_DEFAULT,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid_i,
    input  logic [AW-1:0]       issue_rs_i,
    input  logic [AW-1:0]       issue_rt_i,
    input  logic [AW-1:0]       issue_rd_i,
    input  logic                issue_wen_i,
    output logic                issue_stall_o,
    input  logic                alu_wb_valid_i,
    input  logic [AW-1:0]       alu_wb_rd_i,
    input  logic [DW-1:0]       alu_wb_dat_i,
    input  logic                lu_wb_valid_i,
    input  logic [AW-1:0]       lu_wb_rd_i,
    input  logic [DW-1:0]       lu_wb_dat_i,
    output logic                lu_wb_ready_o,
    output logic                rf_we_o,
    output logic [AW-1:0]       rf_waddr_o,
    output logic [DW-1:0]       rf_wdat_o,
    output logic [NUM_REGS-1:0] pend_o
);

    logic      issue_stall;
    logic      force_bubble;
    logic      lu_blocked;
    lu_state_e state_q;

    // Write port mux: ALU has priority. Address/data follow the long unit when idle.
    always_comb begin
        rf_we_o       = alu_wb_valid_i || lu_wb_valid_i;
        rf_waddr_o    = alu_wb_valid_i ? alu_wb_rd_i  : lu_wb_rd_i;
        rf_wdat_o     = alu_wb_valid_i ? alu_wb_dat_i : lu_wb_dat_i;
        lu_wb_ready_o = lu_wb_valid_i && !alu_wb_valid_i;
    end

    assign lu_blocked = lu_wb_valid_i && alu_wb_valid_i;

`ifdef REGWB_STARVE_EN
    localparam int unsigned CntW   = $clog2(STARVE_LIM) + 1;
    localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIM - 1);

    logic [CntW-1:0] starve_cnt_q;
    logic [CntW-1:0] cnt_inc;
    logic            force_bubble_q;

    assign cnt_inc = (starve_cnt_q == CntMax) ? starve_cnt_q : starve_cnt_q + CntW'(1);

    // The cycle that moves IDLE->WAIT counts as the first blocked cycle, so FORCE is entered
    // after STARVE_LIM blocked cycles and the bubble appears on the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            starve_cnt_q   <= '0;
            force_bubble_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    starve_cnt_q   <= '0;
                    force_bubble_q <= 1'b0;
                    if (lu_blocked) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lu_wb_ready_o) begin
                        state_q      <= ST_IDLE;
                        starve_cnt_q <= '0;
                    end else if (lu_blocked) begin
                        starve_cnt_q <= cnt_inc;
                        if (cnt_inc == CntMax) begin
                            state_q        <= ST_FORCE;
                            force_bubble_q <= 1'b1;
                        end
                    end
                end
                ST_FORCE: begin
                    if (lu_wb_ready_o) begin
                        state_q        <= ST_IDLE;
                        starve_cnt_q   <= '0;
                        force_bubble_q <= 1'b0;
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    starve_cnt_q   <= '0;
                    force_bubble_q <= 1'b0;
                end
            endcase
        end
    end

    assign force_bubble = force_bubble_q;
`else
    logic unused_starve_lim;

    assign unused_starve_lim = ^STARVE_LIM;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (lu_blocked) state_q <= ST_WAIT;
                ST_WAIT: if (lu_wb_ready_o) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign force_bubble = 1'b0;
`endif

    regwb_scoreboard #(
        .AW (AW)
    ) u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .set_en_i       (issue_valid_i && !issue_stall && issue_wen_i),
        .set_addr_i     (issue_rd_i),
        .clr_en_i       (rf_we_o),
        .clr_addr_i     (rf_waddr_o),
        .issue_valid_i  (issue_valid_i),
        .issue_wen_i    (issue_wen_i),
        .issue_rs_i     (issue_rs_i),
        .issue_rt_i     (issue_rt_i),
        .issue_rd_i     (issue_rd_i),
        .force_bubble_i (force_bubble),
        .issue_stall_o  (issue_stall),
        .pend_o         (pend_o)
    );

    assign issue_stall_o = issue_stall;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: a vector table for single-cycle behaviour plus a
// hand-written reset/starvation sequence. Expected stall under starvation depends on whether
// REGWB_STARVE_EN is defined for the build.
module tb_regfile_wb_sched;

`ifdef REGWB_STARVE_EN
    localparam bit StarveEn = 1'b1;
`else
    localparam bit StarveEn = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        issue_valid, issue_wen, issue_stall;
    logic [4:0]  issue_rs, issue_rt, issue_rd;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_dat;
    logic        lu_wb_valid, lu_wb_ready;
    logic [4:0]  lu_wb_rd;
    logic [31:0] lu_wb_dat;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdat;
    logic [31:0] pend;

    int n_vec = 0;
    int n_err = 0;

    regfile_wb_sched #(
        .AW         (5),
        .DW         (32),
        .STARVE_LIM (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid_i  (issue_valid),
        .issue_rs_i     (issue_rs),
        .issue_rt_i     (issue_rt),
        .issue_rd_i     (issue_rd),
        .issue_wen_i    (issue_wen),
        .issue_stall_o  (issue_stall),
        .alu_wb_valid_i (alu_wb_valid),
        .alu_wb_rd_i    (alu_wb_rd),
        .alu_wb_dat_i   (alu_wb_dat),
        .lu_wb_valid_i  (lu_wb_valid),
        .lu_wb_rd_i     (lu_wb_rd),
        .lu_wb_dat_i    (lu_wb_dat),
        .lu_wb_ready_o  (lu_wb_ready),
        .rf_we_o        (rf_we),
        .rf_waddr_o     (rf_waddr),
        .rf_wdat_o      (rf_wdat),
        .pend_o         (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [4:0]  rs, rt, rd;
        logic        wen;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        e_stall, e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdat;
        logic        e_lrdy;
        logic [31:0] e_pend;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [4:0] rs, rt, rd, input logic wen,
                                input logic av, input logic [4:0] ard, input logic [31:0] adat,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                                input logic es, ew, input logic [4:0] ewa,
                                input logic [31:0] ewd, input logic el, input logic [31:0] ep);
        vec_t v;
        v.iv = iv; v.rs = rs; v.rt = rt; v.rd = rd; v.wen = wen;
        v.av = av; v.ard = ard; v.adat = adat;
        v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.e_stall = es; v.e_we = ew; v.e_waddr = ewa; v.e_wdat = ewd;
        v.e_lrdy = el; v.e_pend = ep;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs, check mid-cycle, then advance past the next edge.
    task automatic apply(input vec_t v, input string tag);
        issue_valid  = v.iv;  issue_rs = v.rs; issue_rt = v.rt; issue_rd = v.rd;
        issue_wen    = v.wen;
        alu_wb_valid = v.av;  alu_wb_rd = v.ard; alu_wb_dat = v.adat;
        lu_wb_valid  = v.lv;  lu_wb_rd  = v.lrd; lu_wb_dat  = v.ldat;
        #3;
        chk({tag, ".stall"}, 32'(issue_stall), 32'(v.e_stall));
        chk({tag, ".we"},    32'(rf_we),       32'(v.e_we));
        chk({tag, ".lrdy"},  32'(lu_wb_ready), 32'(v.e_lrdy));
        chk({tag, ".pend"},  pend,             v.e_pend);
        if (v.e_we) begin
            chk({tag, ".waddr"}, 32'(rf_waddr), 32'(v.e_waddr));
            chk({tag, ".wdat"},  rf_wdat,       v.e_wdat);
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t idle;

    initial begin
        idle = mk(0,0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0, 0);
        // RAW on r3 through the ALU
        tbl.push_back(idle);
        tbl.push_back(mk(1,1,2,3,1, 0,0,0,            0,0,0,            0,0,0,0,0,            0));
        tbl.push_back(mk(1,3,4,5,1, 0,0,0,            0,0,0,            1,0,0,0,0,            32'h8));
        tbl.push_back(mk(1,3,4,5,1, 1,3,32'h33,       0,0,0,            1,1,3,32'h33,0,       32'h8));
        tbl.push_back(mk(1,3,4,5,1, 0,0,0,            0,0,0,            0,0,0,0,0,            0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,            0,0,0,            0,0,0,0,0,            32'h20));
        // ALU and long unit together: ALU first, long unit next idle cycle
        tbl.push_back(mk(0,0,0,0,0, 1,5,32'hA5,       1,7,32'h77,       0,1,5,32'hA5,0,       32'h20));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,            1,7,32'h77,       0,1,7,32'h77,1,       0));
        tbl.push_back(idle);
        // r0 is never pending
        tbl.push_back(mk(1,1,2,0,1, 0,0,0,            0,0,0,            0,0,0,0,0,            0));
        tbl.push_back(mk(1,0,0,0,1, 0,0,0,            0,0,0,            0,0,0,0,0,            0));
        tbl.push_back(mk(0,0,0,0,0, 1,0,32'hDEAD,     0,0,0,            0,1,0,32'hDEAD,0,     0));
        // WAW on r9 via the long unit, with one blocked cycle
        tbl.push_back(mk(1,1,2,9,1, 0,0,0,            0,0,0,            0,0,0,0,0,            0));
        tbl.push_back(mk(1,1,2,9,1, 0,0,0,            0,0,0,            1,0,0,0,0,            32'h200));
        tbl.push_back(mk(1,1,2,9,1, 1,10,32'h10,      1,9,32'h99,       1,1,10,32'h10,0,      32'h200));
        tbl.push_back(mk(1,1,2,9,1, 0,0,0,            1,9,32'h99,       1,1,9,32'h99,1,       32'h200));
        tbl.push_back(mk(1,1,2,9,1, 0,0,0,            0,0,0,            0,0,0,0,0,            0));
        tbl.push_back(mk(0,0,0,0,0, 0,0,0,            0,0,0,            0,0,0,0,0,            32'h200));
        tbl.push_back(mk(0,0,0,0,0, 1,9,32'h1,        0,0,0,            0,1,9,32'h1,0,        32'h200));
        tbl.push_back(idle);
        // rt hazard, invalid issue, and rd pending without wen
        tbl.push_back(mk(1,0,0,12,1, 0,0,0,           0,0,0,            0,0,0,0,0,            0));
        tbl.push_back(mk(0,12,12,12,1, 0,0,0,         0,0,0,            0,0,0,0,0,            32'h1000));
        tbl.push_back(mk(1,0,12,12,0, 0,0,0,          0,0,0,            1,0,0,0,0,            32'h1000));
        tbl.push_back(mk(1,1,2,12,0, 0,0,0,           0,0,0,            0,0,0,0,0,            32'h1000));
        tbl.push_back(mk(0,0,0,0,0, 1,12,32'hC,       0,0,0,            0,1,12,32'hC,0,       32'h1000));
        tbl.push_back(idle);

        rst = 1'b1;
        issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_rd = 0; issue_wen = 0;
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_dat = 0;
        lu_wb_valid = 0; lu_wb_rd = 0; lu_wb_dat = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));

        // Reset mid-operation: r3 and r9 pending, FSM two blocked cycles into WAIT.
        apply(mk(1,1,2,3,1, 0,0,0, 0,0,0,        0,0,0,0,0, 0),           "r1");
        apply(mk(1,1,2,9,1, 0,0,0, 0,0,0,        0,0,0,0,0, 32'h8),       "r2");
        for (int k = 0; k < 3; k++) begin
            apply(mk(1,1,2,0,0, 1,0,0, 1,9,32'h99, 0,1,0,0,0, 32'h208),   $sformatf("r3_%0d", k));
        end
        rst = 1'b1;
        apply(mk(0,0,0,0,0, 1,4,32'h44, 0,0,0,   0,1,4,32'h44,0, 32'h208), "rst");
        rst = 1'b0;
        apply(mk(1,3,9,9,1, 0,0,0, 0,0,0,        0,0,0,0,0, 0),           "r7");
        // Starvation: six blocked cycles, then ALU idles and the long unit takes the port.
        for (int k = 0; k < 6; k++) begin
            apply(mk(1,1,2,0,0, 1,0,0, 1,9,32'h99, StarveEn && (k >= 4), 1,0,0,0, 32'h200),
                  $sformatf("st%0d", k));
        end
        apply(mk(1,1,2,0,0, 0,0,0, 1,9,32'h99,   StarveEn,1,9,32'h99,1, 32'h200), "grant");
        apply(mk(1,1,2,0,0, 0,0,0, 0,0,0,        0,0,0,0,0, 0),           "after");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
